// File: rtl/morse_ram_arbiter.sv
// Round-robin owner of the single-port morse RAM (ram32x10): P1 writes, P2 and VID
// read with registered data return, plus a full-memory clear sequencer.
module morse_ram_arbiter #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 10,
   parameter int unsigned DEPTH  = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              write_en,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic              clear_done,
   input  logic              p1_req,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_data,
   output logic              p1_ack,
   input  logic              p2_req,
   input  logic [ADDR_W-1:0] p2_addr,
   output logic              p2_ack,
   output logic              p2_rvalid,
   output logic [DATA_W-1:0] p2_rdata,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic              vid_rvalid,
   output logic [DATA_W-1:0] vid_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RD_WAIT, S_CLEAR} state_e;
   typedef enum logic [1:0] {REQ_P1, REQ_P2, REQ_VID} req_e;

   state_e            state_q, state_d;
   req_e              rr_q, rr_d;
   req_e              owner_q, owner_d;
   logic              pend_q, pend_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [2:0]        ack_q, ack_d;
   logic              p2_rvalid_q, p2_rvalid_d;
   logic              vid_rvalid_q, vid_rvalid_d;
   logic [DATA_W-1:0] p2_rdata_q, p2_rdata_d;
   logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_data_q, ram_data_d;
   logic              ram_wren_q, ram_wren_d;

   logic [2:0]        elig_c;
   logic [2:0]        rot_c;
   req_e              win_c;

   function automatic req_e next_req(input req_e r);
      case (r)
         REQ_P1:  return REQ_P2;
         REQ_P2:  return REQ_VID;
         default: return REQ_P1;
      endcase
   endfunction

   // Rotate eligibility so bit 0 is the requester the pointer favours, then pick the first.
   always_comb begin
      elig_c = {vid_req, p2_req, p1_req & write_en};
      case (rr_q)
         REQ_P2:  rot_c = {elig_c[0], elig_c[2], elig_c[1]};
         REQ_VID: rot_c = {elig_c[1], elig_c[0], elig_c[2]};
         default: rot_c = elig_c;
      endcase
      win_c = rr_q;
      if (!rot_c[0]) begin
         win_c = next_req(win_c);
         if (!rot_c[1]) win_c = next_req(win_c);
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      owner_d      = owner_q;
      pend_d       = pend_q | (clear_start & (state_q != S_CLEAR));
      done_d       = 1'b0;
      ack_d        = '0;
      p2_rvalid_d  = 1'b0;
      vid_rvalid_d = 1'b0;
      p2_rdata_d   = p2_rdata_q;
      vid_rdata_d  = vid_rdata_q;
      ram_addr_d   = ram_addr_q;
      ram_data_d   = ram_data_q;
      ram_wren_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (pend_d) begin
               state_d    = S_CLEAR;
               pend_d     = 1'b0;
               ram_addr_d = '0;
               ram_data_d = '0;
               ram_wren_d = 1'b1;
            end else if (|elig_c) begin
               state_d = S_ACCESS;
               owner_d = win_c;
               rr_d    = next_req(win_c);
               case (win_c)
                  REQ_P1: begin
                     ack_d[0]   = 1'b1;
                     ram_addr_d = p1_addr;
                     ram_data_d = p1_data;
                     ram_wren_d = 1'b1;
                  end
                  REQ_P2: begin
                     ack_d[1]   = 1'b1;
                     ram_addr_d = p2_addr;
                  end
                  default: begin
                     ack_d[2]   = 1'b1;
                     ram_addr_d = vid_addr;
                  end
               endcase
            end
         end
         S_ACCESS: begin
            state_d = (owner_q == REQ_P1) ? S_IDLE : S_RD_WAIT;
         end
         S_RD_WAIT: begin
            state_d = S_IDLE;
            if (owner_q == REQ_P2) begin
               p2_rvalid_d = 1'b1;
               p2_rdata_d  = ram_q;
            end else begin
               vid_rvalid_d = 1'b1;
               vid_rdata_d  = ram_q;
            end
         end
         S_CLEAR: begin
            // ram_addr_q doubles as the sweep counter
            if (ram_addr_q == ADDR_W'(DEPTH - 1)) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               ram_addr_d = ram_addr_q + ADDR_W'(1);
               ram_wren_d = 1'b1;
            end
         end
      endcase
      busy_d = pend_d | (state_d == S_CLEAR);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         rr_q         <= REQ_P1;
         owner_q      <= REQ_P1;
         pend_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         ack_q        <= '0;
         p2_rvalid_q  <= 1'b0;
         vid_rvalid_q <= 1'b0;
         p2_rdata_q   <= '0;
         vid_rdata_q  <= '0;
         ram_addr_q   <= '0;
         ram_data_q   <= '0;
         ram_wren_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         owner_q      <= owner_d;
         pend_q       <= pend_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         ack_q        <= ack_d;
         p2_rvalid_q  <= p2_rvalid_d;
         vid_rvalid_q <= vid_rvalid_d;
         p2_rdata_q   <= p2_rdata_d;
         vid_rdata_q  <= vid_rdata_d;
         ram_addr_q   <= ram_addr_d;
         ram_data_q   <= ram_data_d;
         ram_wren_q   <= ram_wren_d;
      end
   end

   assign clear_busy = busy_q;
   assign clear_done = done_q;
   assign p1_ack     = ack_q[0];
   assign p2_ack     = ack_q[1];
   assign vid_ack    = ack_q[2];
   assign p2_rvalid  = p2_rvalid_q;
   assign p2_rdata   = p2_rdata_q;
   assign vid_rvalid = vid_rvalid_q;
   assign vid_rdata  = vid_rdata_q;
   assign ram_addr   = ram_addr_q;
   assign ram_data   = ram_data_q;
   assign ram_wren   = ram_wren_q;

endmodule

// File: tb/tb_morse_ram_arbiter.sv
// Bench for morse_ram_arbiter: directed scenarios and randomized handshake traffic,
// checked every cycle against a schedule-based transaction model.
module tb_morse_ram_arbiter;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 10;
   localparam int unsigned DEPTH  = 32;
   localparam int          RING   = 64;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              write_en = 1'b0, clear_start = 1'b0;
   logic              clear_busy, clear_done;
   logic              p1_req = 1'b0, p2_req = 1'b0, vid_req = 1'b0;
   logic [ADDR_W-1:0] p1_addr = '0, p2_addr = '0, vid_addr = '0;
   logic [DATA_W-1:0] p1_data = '0;
   logic              p1_ack, p2_ack, vid_ack, p2_rvalid, vid_rvalid;
   logic [DATA_W-1:0] p2_rdata, vid_rdata;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_data;
   logic              ram_wren;
   logic [DATA_W-1:0] ram_q = '0;

   int total = 0;
   int bad   = 0;

   morse_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .write_en(write_en), .clear_start(clear_start),
      .clear_busy(clear_busy), .clear_done(clear_done),
      .p1_req(p1_req), .p1_addr(p1_addr), .p1_data(p1_data), .p1_ack(p1_ack),
      .p2_req(p2_req), .p2_addr(p2_addr), .p2_ack(p2_ack), .p2_rvalid(p2_rvalid),
      .p2_rdata(p2_rdata),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rvalid(vid_rvalid),
      .vid_rdata(vid_rdata),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
   );

   always #5 clock = ~clock;

   // ram32x10 stand-in: address captured at the edge, q valid the following cycle
   logic [DATA_W-1:0] ram_mem [2**ADDR_W];
   initial for (int i = 0; i < 2**ADDR_W; i++) ram_mem[i] = '0;
   always @(posedge clock) begin
      ram_q <= ram_mem[ram_addr];
      if (ram_wren) ram_mem[ram_addr] = ram_data;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction model: schedules expected outputs per cycle --------
   int                mcyc = 0, next_idle = 0, clr_lo = -100, clr_hi = -100, rr = 0;
   bit                pend = 1'b0;
   logic [DATA_W-1:0] mmem [2**ADDR_W];
   logic [2:0]        e_ack  [RING];
   logic              e_rv2  [RING], e_rvv [RING];
   logic [DATA_W-1:0] e_rd2  [RING], e_rdv [RING];
   logic              e_wren [RING], e_chka [RING], e_chkd [RING], e_done [RING], e_busy [RING];
   logic [ADDR_W-1:0] e_addr [RING];
   logic [DATA_W-1:0] e_data [RING];

   function automatic void clear_slot(input int s);
      e_ack[s] = '0; e_rv2[s] = 0; e_rvv[s] = 0; e_rd2[s] = '0; e_rdv[s] = '0;
      e_wren[s] = 0; e_chka[s] = 0; e_chkd[s] = 0; e_done[s] = 0; e_busy[s] = 0;
      e_addr[s] = '0; e_data[s] = '0;
   endfunction

   initial for (int i = 0; i < 2**ADDR_W; i++) mmem[i] = '0;

   always @(posedge clock) begin
      int s, w, p;
      bit el;
      if (reset) begin
         for (int i = 0; i < RING; i++) clear_slot(i);
         next_idle = mcyc + 1; rr = 0; pend = 0; clr_lo = -100; clr_hi = -100;
      end else begin
         clear_slot(mcyc % RING);
         if (mcyc == next_idle) begin
            if (pend || clear_start) begin
               pend = 0; clr_lo = mcyc + 1; clr_hi = mcyc + DEPTH;
               for (int k = 0; k < DEPTH; k++) begin
                  s = (mcyc + 1 + k) % RING;
                  e_wren[s] = 1; e_chka[s] = 1; e_chkd[s] = 1;
                  e_addr[s] = ADDR_W'(k); e_data[s] = '0;
                  mmem[k] = '0;
               end
               e_done[(mcyc + 1 + DEPTH) % RING] = 1;
               next_idle = mcyc + 1 + DEPTH;
            end else begin
               w = -1;
               for (int i = 0; i < 3; i++) begin
                  p  = (rr + i) % 3;
                  el = (p == 0) ? (p1_req && write_en) : (p == 1) ? p2_req : vid_req;
                  if (w < 0 && el) w = p;
               end
               s = (mcyc + 1) % RING;
               if (w < 0) next_idle = mcyc + 1;
               else begin
                  rr = (w + 1) % 3;
                  e_chka[s] = 1;
                  if (w == 0) begin
                     e_ack[s] = 3'b001; e_wren[s] = 1; e_chkd[s] = 1;
                     e_addr[s] = p1_addr; e_data[s] = p1_data;
                     mmem[p1_addr] = p1_data;
                     next_idle = mcyc + 2;
                  end else if (w == 1) begin
                     e_ack[s] = 3'b010; e_addr[s] = p2_addr;
                     e_rv2[(mcyc + 3) % RING] = 1; e_rd2[(mcyc + 3) % RING] = mmem[p2_addr];
                     next_idle = mcyc + 3;
                  end else begin
                     e_ack[s] = 3'b100; e_addr[s] = vid_addr;
                     e_rvv[(mcyc + 3) % RING] = 1; e_rdv[(mcyc + 3) % RING] = mmem[vid_addr];
                     next_idle = mcyc + 3;
                  end
               end
            end
         end else if (clear_start && !(mcyc >= clr_lo && mcyc <= clr_hi)) begin
            pend = 1;
         end
         e_busy[(mcyc + 1) % RING] = pend || (mcyc + 1 >= clr_lo && mcyc + 1 <= clr_hi);
      end
      mcyc++;
   end

   // Per-cycle comparison of every output against the model's schedule.
   logic [DATA_W-1:0] hold2 = '0, holdv = '0;
   always @(negedge clock) begin
      int s;
      s = mcyc % RING;
      if (reset) begin
         hold2 = '0; holdv = '0;
      end else begin
         if (e_rv2[s]) hold2 = e_rd2[s];
         if (e_rvv[s]) holdv = e_rdv[s];
         chk("p1_ack",     32'(p1_ack),     32'(e_ack[s][0]));
         chk("p2_ack",     32'(p2_ack),     32'(e_ack[s][1]));
         chk("vid_ack",    32'(vid_ack),    32'(e_ack[s][2]));
         chk("p2_rvalid",  32'(p2_rvalid),  32'(e_rv2[s]));
         chk("vid_rvalid", 32'(vid_rvalid), 32'(e_rvv[s]));
         chk("p2_rdata",   32'(p2_rdata),   32'(hold2));
         chk("vid_rdata",  32'(vid_rdata),  32'(holdv));
         chk("ram_wren",   32'(ram_wren),   32'(e_wren[s]));
         chk("clear_done", 32'(clear_done), 32'(e_done[s]));
         chk("clear_busy", 32'(clear_busy), 32'(e_busy[s]));
         if (e_chka[s]) chk("ram_addr", 32'(ram_addr), 32'(e_addr[s]));
         if (e_chkd[s]) chk("ram_data", 32'(ram_data), 32'(e_data[s]));
      end
   end

   // ---------------- directed helpers ----------------
   int glog[$];

   task automatic step(input int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic log_grants(input int n);
      repeat (n) begin
         @(negedge clock);
         if (p1_ack) glog.push_back(0);
         if (p2_ack) glog.push_back(1);
         if (vid_ack) glog.push_back(2);
      end
   endtask

   task automatic drop_all();
      p1_req = 0; p2_req = 0; vid_req = 0; clear_start = 0;
   endtask

   task automatic do_reset();
      reset = 1; drop_all(); write_en = 0;
      step(3);
      reset = 0;
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      int n;
      p1_addr = a; p1_data = d; p1_req = 1; n = 0;
      do begin @(negedge clock); n++; end while (!p1_ack && n < 60);
      chk("wr_ack", 32'(p1_ack), 32'd1);
      @(posedge clock); #1; p1_req = 0;
   endtask

   task automatic rd(input bit use_vid, input logic [ADDR_W-1:0] a,
                     output logic [DATA_W-1:0] d);
      int n;
      if (use_vid) begin vid_addr = a; vid_req = 1; end
      else begin p2_addr = a; p2_req = 1; end
      n = 0;
      do begin @(negedge clock); n++; end while (!(use_vid ? vid_ack : p2_ack) && n < 60);
      chk("rd_ack", 32'(use_vid ? vid_ack : p2_ack), 32'd1);
      @(posedge clock); #1; vid_req = 0; p2_req = 0;
      n = 0;
      do begin @(negedge clock); n++; end while (!(use_vid ? vid_rvalid : p2_rvalid) && n < 10);
      chk("rd_rvalid", 32'(use_vid ? vid_rvalid : p2_rvalid), 32'd1);
      d = use_vid ? vid_rdata : p2_rdata;
      @(posedge clock); #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [DATA_W-1:0] d;
      logic [2:0]        a;
      int                n, busy_n, done_n, rv_c, done_c, vid_c;

      step(3);
      @(negedge clock);
      chk("rst_p1_ack", 32'(p1_ack), 0);
      chk("rst_ram_wren", 32'(ram_wren), 0);
      chk("rst_clear_busy", 32'(clear_busy), 0);
      chk("rst_p2_rdata", 32'(p2_rdata), 0);

      // 1: write then read back
      @(posedge clock); #1;
      reset = 0; write_en = 1; p1_req = 1; p1_addr = 3; p1_data = 10'h2A5;
      @(negedge clock); chk("t1_ack_early", 32'(p1_ack), 0);
      @(posedge clock); #1;
      @(negedge clock);
      chk("t1_p1_ack", 32'(p1_ack), 1);
      chk("t1_wren", 32'(ram_wren), 1);
      chk("t1_addr", 32'(ram_addr), 3);
      chk("t1_data", 32'(ram_data), 32'h2A5);
      @(posedge clock); #1; p1_req = 0; p2_req = 1; p2_addr = 3;
      @(posedge clock); #1;
      @(negedge clock); chk("t1_p2_ack", 32'(p2_ack), 1);
      @(posedge clock); #1; p2_req = 0;
      @(negedge clock); chk("t1_rv_early", 32'(p2_rvalid), 0);
      @(posedge clock); #1;
      @(negedge clock);
      chk("t1_p2_rvalid", 32'(p2_rvalid), 1);
      chk("t1_p2_rdata", 32'(p2_rdata), 32'h2A5);

      // 2: everyone requesting continuously from reset
      @(posedge clock); #1;
      do_reset();
      write_en = 1; p1_req = 1; p1_addr = 0; p1_data = 1; p2_req = 1; vid_req = 1;
      glog.delete();
      log_grants(17);
      chk("t2_count", 32'(glog.size() >= 6), 1);
      for (int i = 0; i < 6 && i < glog.size(); i++) chk("t2_order", 32'(glog[i]), 32'(i % 3));

      // 3: write_en low blocks only P1
      @(posedge clock); #1;
      write_en = 0; p2_req = 0;
      step(3);
      glog.delete();
      log_grants(12);
      n = 0;
      foreach (glog[i]) if (glog[i] == 0) n++;
      chk("t3_no_p1", 32'(n), 0);
      chk("t3_vid_served", 32'(glog.size() >= 2), 1);
      @(posedge clock); #1;
      write_en = 1;
      glog.delete();
      n = 0;
      while (glog.size() == 0 && n < 10) begin log_grants(1); n++; end
      chk("t3_p1_next", 32'(glog.size() > 0 ? glog[0] : 9), 0);
      @(posedge clock); #1; drop_all();
      step(4);

      // 4: fill, clear, read back zeros
      for (int i = 0; i < 32; i++) wr(ADDR_W'(i), DATA_W'(i * 37 + 1));
      rd(1'b1, 5, d);
      chk("t4_pre", 32'(d), 32'd186);
      clear_start = 1;
      step(1);
      clear_start = 0;
      busy_n = 0; done_n = 0;
      repeat (40) begin
         @(negedge clock);
         if (clear_busy) busy_n++;
         if (clear_done) done_n++;
      end
      chk("t4_busy_len", 32'(busy_n >= 32 && busy_n <= 33), 1);
      chk("t4_done_once", 32'(done_n), 1);
      @(posedge clock); #1;
      for (int i = 0; i < 32; i++) begin
         rd(1'b0, ADDR_W'(i), d);
         chk("t4_zero", 32'(d), 0);
      end

      // 5: clear_start during a P2 read
      step(3);
      p2_addr = 7; p2_req = 1;
      step(1);
      p2_req = 0; clear_start = 1; vid_req = 1; vid_addr = 7;
      step(1);
      clear_start = 0;
      @(negedge clock); chk("t5_pending", 32'(clear_busy), 1);
      rv_c = -1; done_c = -1; vid_c = -1; n = 2;
      while (vid_c < 0 && n < 80) begin
         if (p2_rvalid && rv_c < 0) rv_c = n;
         if (clear_done && done_c < 0) done_c = n;
         if (vid_ack) vid_c = n;
         @(negedge clock); n++;
      end
      @(posedge clock); #1; vid_req = 0;
      chk("t5_rv_at3", 32'(rv_c), 3);
      chk("t5_clear_gap", 32'(done_c - rv_c), 32'(DEPTH + 1));
      chk("t5_vid_after", 32'(vid_c - done_c), 1);

      // 6: reset during RD_WAIT
      step(3);
      wr(7, 10'h155);
      rd(1'b0, 7, d);
      chk("t6_pre", 32'(d), 32'h155);
      step(2);
      p2_addr = 7; p2_req = 1;
      step(1);
      p2_req = 0;
      step(1);
      reset = 1;
      #1;
      chk("t6_rvalid", 32'(p2_rvalid), 0);
      chk("t6_rdata", 32'(p2_rdata), 0);
      chk("t6_wren", 32'(ram_wren), 0);
      chk("t6_addr", 32'(ram_addr), 0);
      repeat (3) begin @(negedge clock); chk("t6_no_rvalid", 32'(p2_rvalid), 0); end
      @(posedge clock); #1;
      reset = 0; write_en = 1; p1_req = 1; p1_addr = 9; p1_data = 1; p2_req = 1; vid_req = 1;
      glog.delete();
      n = 0;
      while (glog.size() == 0 && n < 10) begin log_grants(1); n++; end
      chk("t6_first_p1", 32'(glog.size() > 0 ? glog[0] : 9), 0);
      @(posedge clock); #1; drop_all();
      step(4);

      // random traffic
      do_reset();
      write_en = 1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clock);
         a = {vid_ack, p2_ack, p1_ack};
         @(posedge clock); #1;
         if (!p1_req || a[0]) begin
            p1_req  = p1_req ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
            p1_addr = ADDR_W'($urandom); p1_data = DATA_W'($urandom);
         end
         if (!p2_req || a[1]) begin
            p2_req  = p2_req ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
            p2_addr = ADDR_W'($urandom);
         end
         if (!vid_req || a[2]) begin
            vid_req  = vid_req ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
            vid_addr = ADDR_W'($urandom);
         end
         if ($urandom_range(0, 19) == 0) write_en = !write_en;
         clear_start = ($urandom_range(0, 199) == 0);
      end
      drop_all();
      step(40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
